// File: rtl/mem_resp_stage_pkg.sv
// Shared types for the memory-response stage: FSM states, the writeback
// record and the data-bus request/response structs.
package mem_resp_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // The memory stage produces the same record shape; valM is filled in here.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] valE;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] valM;
  } plr_w;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // A request with no byte strobes is a read whose data returns in valM.
  function automatic logic is_load(input dbus_req_t req);
    return req.strobe == 4'b0000;
  endfunction

endpackage

// File: rtl/mem_resp_watchdog.sv
// Bus watchdog: counts cycles spent waiting on the data bus and raises a
// sticky error once TIMEOUT wait cycles pass without a data response.
module mem_resp_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic fire,
  output logic bus_err
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count;

  // A response arriving in the final wait cycle still wins over the timeout.
  assign fire = busy && (count == LIMIT) && !done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (start) begin
        count <= '0;
      end else if (busy) begin
        count <= count + 16'd1;
      end
      if (fire) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_resp_stage.sv
// Memory-response stage: issues the buffered data-bus request and returns
// the writeback record. Optional watchdog enabled by MEM_RESP_WATCHDOG_EN.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_valid,
  input  plr_w       r_m,
  input  dbus_req_t  dreq_in,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       stall,
  output logic       w_valid,
  output plr_w       r_w,
  output logic       bus_err
);

  state_t    state;
  dbus_req_t req_buf;
  plr_w      rec_buf;
  logic      timeout;
  logic      start_req;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_resp_stage: TIMEOUT must be in 1..65535");
  end

  assign start_req = (state == IDLE) && m_valid && dreq_in.valid;
  assign stall     = (state != IDLE) || (m_valid && dreq_in.valid);

  // The bus only sees the buffered copy, so upstream changes cannot leak out.
  always_comb begin
    dreq       = req_buf;
    dreq.valid = (state == ADDR);
  end

`ifdef MEM_RESP_WATCHDOG_EN
  mem_resp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (start_req),
    .busy    (state != IDLE),
    .done    (dresp.data_ok),
    .fire    (timeout),
    .bus_err (bus_err)
  );
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      w_valid <= 1'b0;
      r_w     <= '0;
      req_buf <= '0;
      rec_buf <= '0;
    end else begin
      w_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_req) begin
            req_buf <= dreq_in;
            rec_buf <= r_m;
            state   <= ADDR;
          end else if (m_valid) begin
            r_w      <= r_m;
            r_w.valM <= '0;
            w_valid  <= 1'b1;
          end
        end
        ADDR, DATA: begin
          if (dresp.data_ok) begin
            r_w      <= rec_buf;
            r_w.valM <= is_load(req_buf) ? dresp.data : '0;
            w_valid  <= 1'b1;
            state    <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
          end else if (state == ADDR && dresp.addr_ok) begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed self-checking bench for mem_resp_stage; the watchdog scenario is
// built only when MEM_RESP_WATCHDOG_EN is defined.
module tb_mem_resp_stage;
  import mem_resp_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_valid;
  plr_w       r_m;
  dbus_req_t  dreq_in;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       stall;
  logic       w_valid;
  plr_w       r_w;
  logic       bus_err;

  int checks = 0;
  int failures = 0;

  mem_resp_stage #(.TIMEOUT(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid),
    .r_m     (r_m),
    .dreq_in (dreq_in),
    .dreq    (dreq),
    .dresp   (dresp),
    .stall   (stall),
    .w_valid (w_valid),
    .r_w     (r_w),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic plr_w mk_rec(input logic [5:0] op, input logic [31:0] vale,
                                  input logic [4:0] dste, input logic [31:0] pc);
    plr_w r;
    r.opcode = op;
    r.valE   = vale;
    r.dstE   = dste;
    r.dstM   = 5'd8;
    r.funct  = 6'd0;
    r.pc     = pc;
    r.valM   = 32'h5A5A5A5A;
    return r;
  endfunction

  function automatic dbus_req_t mk_req(input logic [31:0] addr, input logic [3:0] strb,
                                       input logic [31:0] data);
    dbus_req_t q;
    q.valid  = 1'b1;
    q.addr   = addr;
    q.size   = MSIZE4;
    q.strobe = strb;
    q.data   = data;
    return q;
  endfunction

  task automatic idle_inputs();
    m_valid = 1'b0;
    r_m     = '0;
    dreq_in = '0;
    dresp   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_wvalid: got %b want 0", w_valid); end
    checks++; if (r_w !== '0) begin failures++; $display("FAIL reset_rw: got %h want 0", r_w); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL reset_dreq_valid: got %b want 0", dreq.valid); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h09, 32'h10, 5'd2, 32'h0040_0000);
    dreq_in = '0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    m_valid = 1'b0;
    #1;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL alu_wvalid: got %b want 1", w_valid); end
    checks++; if (r_w.valE !== 32'h10) begin failures++; $display("FAIL alu_valE: got %h want 10", r_w.valE); end
    checks++; if (r_w.valM !== 32'h0) begin failures++; $display("FAIL alu_valM: got %h want 0", r_w.valM); end
    checks++; if (r_w.dstE !== 5'd2) begin failures++; $display("FAIL alu_dstE: got %0d want 2", r_w.dstE); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall_after: got %b want 0", stall); end
    tick();
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse: got %b want 0", w_valid); end
    checks++; if (r_w.valE !== 32'h10) begin failures++; $display("FAIL alu_hold: got %h want 10", r_w.valE); end
  endtask

  task automatic test_load();
    // cycle 0
    m_valid = 1'b1;
    r_m     = mk_rec(6'h23, 32'h8000_0100, 5'd0, 32'h0040_0010);
    dreq_in = mk_req(32'h8000_0100, 4'b0000, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_c0_stall: got %b want 1", stall); end
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL lw_c0_dreq: got %b want 0", dreq.valid); end
    tick(); // cycle 1
    checks++; if (dreq.valid !== 1'b1) begin failures++; $display("FAIL lw_c1_dreq: got %b want 1", dreq.valid); end
    checks++; if (dreq.addr !== 32'h8000_0100) begin failures++; $display("FAIL lw_c1_addr: got %h want 80000100", dreq.addr); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_c1_stall: got %b want 1", stall); end
    tick(); // cycle 2
    dresp.addr_ok = 1'b1;
    #1;
    checks++; if (dreq.valid !== 1'b1) begin failures++; $display("FAIL lw_c2_dreq: got %b want 1", dreq.valid); end
    tick(); // cycle 3
    dresp.addr_ok = 1'b0;
    #1;
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL lw_c3_dreq: got %b want 0", dreq.valid); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_c3_stall: got %b want 1", stall); end
    tick(); // cycle 4
    dresp.data_ok = 1'b1;
    dresp.data    = 32'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_c4_stall: got %b want 1", stall); end
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL lw_c4_wvalid: got %b want 0", w_valid); end
    tick(); // cycle 5
    idle_inputs();
    #1;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL lw_c5_wvalid: got %b want 1", w_valid); end
    checks++; if (r_w.valM !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_c5_valM: got %h want deadbeef", r_w.valM); end
    checks++; if (r_w.pc !== 32'h0040_0010) begin failures++; $display("FAIL lw_c5_pc: got %h want 00400010", r_w.pc); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_c5_stall: got %b want 0", stall); end
    tick(); // cycle 6
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL lw_c6_pulse: got %b want 0", w_valid); end
  endtask

  task automatic test_store_same_cycle();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h2B, 32'h8000_0200, 5'd0, 32'h0040_0020);
    dreq_in = mk_req(32'h8000_0200, 4'b1111, 32'h1234_5678);
    tick(); // ADDR
    checks++; if (dreq.strobe !== 4'b1111) begin failures++; $display("FAIL sw_strobe: got %b want 1111", dreq.strobe); end
    checks++; if (dreq.data !== 32'h1234_5678) begin failures++; $display("FAIL sw_data: got %h want 12345678", dreq.data); end
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 32'hAAAA_5555;
    tick();
    idle_inputs();
    #1;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL sw_wvalid: got %b want 1", w_valid); end
    checks++; if (r_w.valM !== 32'h0) begin failures++; $display("FAIL sw_valM: got %h want 0", r_w.valM); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sw_idle_stall: got %b want 0", stall); end
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL sw_idle_dreq: got %b want 0", dreq.valid); end
    tick();
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL sw_pulse: got %b want 0", w_valid); end
  endtask

  task automatic test_hold_request();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h23, 32'h0000_0A00, 5'd0, 32'h0040_0030);
    dreq_in = mk_req(32'h0000_0A00, 4'b0000, 32'h1111_1111);
    tick(); // ADDR
    r_m     = mk_rec(6'h23, 32'h0000_0B00, 5'd0, 32'h0040_0099);
    dreq_in = mk_req(32'h0000_0B00, 4'b0011, 32'h2222_2222);
    #1;
    checks++; if (dreq.addr !== 32'h0000_0A00) begin failures++; $display("FAIL hold_addr: got %h want 00000a00", dreq.addr); end
    checks++; if (dreq.data !== 32'h1111_1111) begin failures++; $display("FAIL hold_data: got %h want 11111111", dreq.data); end
    tick();
    checks++; if (dreq.addr !== 32'h0000_0A00) begin failures++; $display("FAIL hold_addr2: got %h want 00000a00", dreq.addr); end
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    #1;
    checks++; if (r_w.pc !== 32'h0040_0030) begin failures++; $display("FAIL hold_pc: got %h want 00400030", r_w.pc); end
    checks++; if (r_w.valM !== 32'h0BAD_F00D) begin failures++; $display("FAIL hold_valM: got %h want 0badf00d", r_w.valM); end
    tick();
  endtask

  task automatic test_reset_in_data();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h23, 32'h0000_0C00, 5'd0, 32'h0040_0040);
    dreq_in = mk_req(32'h0000_0C00, 4'b0000, 32'h0);
    tick(); // ADDR
    dresp.addr_ok = 1'b1;
    tick(); // DATA
    dresp.addr_ok = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_data_stall: got %b want 1", stall); end
    #2;
    reset   = 1'b1;
    m_valid = 1'b0;
    dreq_in = '0;
    #1;
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL rst_async_dreq: got %b want 0", dreq.valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_async_stall: got %b want 0", stall); end
    tick();
    reset         = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data    = 32'hCAFE_0001;
    tick();
    dresp = '0;
    #1;
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL rst_late_wvalid: got %b want 0", w_valid); end
    checks++; if (r_w !== '0) begin failures++; $display("FAIL rst_late_rw: got %h want 0", r_w); end
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL rst_late_dreq: got %b want 0", dreq.valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_late_stall: got %b want 0", stall); end
    tick();
  endtask

`ifdef MEM_RESP_WATCHDOG_EN
  task automatic test_watchdog();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h23, 32'h0000_0D00, 5'd0, 32'h0040_0050);
    dreq_in = mk_req(32'h0000_0D00, 4'b0000, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) begin
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL wd_early_err: got %b want 0", bus_err); end
        checks++; if (dreq.valid !== 1'b1) begin failures++; $display("FAIL wd_last_dreq: got %b want 1", dreq.valid); end
      end
      checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL wd_wvalid_c%0d: got %b want 0", c, w_valid); end
    end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL wd_bus_err: got %b want 1", bus_err); end
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL wd_dropped: got %b want 0", w_valid); end
    checks++; if (dreq.valid !== 1'b0) begin failures++; $display("FAIL wd_idle_dreq: got %b want 0", dreq.valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wd_idle_stall: got %b want 0", stall); end
    m_valid = 1'b1;
    r_m     = mk_rec(6'h09, 32'h77, 5'd3, 32'h0040_0054);
    tick();
    idle_inputs();
    #1;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL wd_after_alu: got %b want 1", w_valid); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL wd_sticky: got %b want 1", bus_err); end
    tick();
  endtask
`else
  task automatic test_no_watchdog();
    m_valid = 1'b1;
    r_m     = mk_rec(6'h23, 32'h0000_0E00, 5'd0, 32'h0040_0060);
    dreq_in = mk_req(32'h0000_0E00, 4'b0000, 32'h0);
    for (int c = 0; c < 20; c++) tick();
    checks++; if (dreq.valid !== 1'b1) begin failures++; $display("FAIL nowd_dreq: got %b want 1", dreq.valid); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL nowd_bus_err: got %b want 0", bus_err); end
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 32'h1357_9BDF;
    tick();
    idle_inputs();
    #1;
    checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL nowd_wvalid: got %b want 1", w_valid); end
    checks++; if (r_w.valM !== 32'h1357_9BDF) begin failures++; $display("FAIL nowd_valM: got %h want 13579bdf", r_w.valM); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_same_cycle();
    test_hold_request();
    test_reset_in_data();
`ifdef MEM_RESP_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter TIMEOUT, default 1023, SHALL set the watchdog limit in cycles spent waiting on the data bus.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 m_valid  in  1  memory-stage record valid this cycle.
REQ-005 r_m  in  plr_w  memory-stage output record: opcode, valE, dstE, dstM, funct, pc.
REQ-006 dreq_in  in  dbus_req_t  bus request computed by the memory stage (valid, addr, size, strobe, data).
REQ-007 dreq  out  dbus_req_t  request actually driven to the data bus.
REQ-008 dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data).
REQ-009 stall  out  1  high while the stage cannot accept a new record; upstream holds r_m and dreq_in.
REQ-010 w_valid  out  1  registered writeback record valid.
REQ-011 r_w  out  plr_w  registered writeback record, with valM carrying load data.
REQ-012 bus_err  out  1  sticky watchdog-timeout flag (REQ-027).

Function
REQ-013 FSM states SHALL be IDLE, ADDR (request driven, awaiting addr_ok) and DATA (address accepted, awaiting data_ok).
REQ-014 IDLE, m_valid=1, dreq_in.valid=0: r_w <= r_m with valM=0, w_valid <= 1, state stays IDLE, stall=0; writeback latency 1 cycle.
REQ-015 IDLE, m_valid=1, dreq_in.valid=1: dreq_in latched into a request buffer, r_m latched into a record buffer, state -> ADDR.
REQ-016 In ADDR, dreq SHALL equal the buffered request with valid=1; in IDLE and DATA, dreq.valid=0.
REQ-017 ADDR, addr_ok=1, data_ok=0: state -> DATA.
REQ-018 ADDR or DATA, data_ok=1 (including addr_ok and data_ok in the same ADDR cycle): r_w <= buffered record; valM <= dresp.data when buffered strobe=4'b0000, else 0; w_valid <= 1; state -> IDLE.
REQ-019 stall SHALL be 1 in ADDR and DATA, and in IDLE when m_valid=1 and dreq_in.valid=1; it is combinational from state and inputs.
REQ-020 w_valid SHALL be 0 in every cycle not covered by REQ-014 or REQ-018 (single-cycle pulse per record).
REQ-021 Buffered request fields SHALL stay stable from entry to ADDR until addr_ok, regardless of dreq_in changes.
REQ-022 IDLE, m_valid=0: w_valid <= 0 and r_w holds its last value.

Reset
REQ-023 Reset SHALL force state=IDLE, w_valid=0, r_w='0, request and record buffers '0, bus_err=0 and watchdog counter 0.
REQ-024 Reset asserted in ADDR or DATA SHALL abandon the transaction; dreq.valid drops immediately and a late data_ok after reset is ignored in IDLE.

Configuration
REQ-025 Macro MEM_RESP_WATCHDOG_EN SHALL gate the watchdog.
REQ-026 Without the macro: no counter; bus_err tied 0; ADDR and DATA wait indefinitely.
REQ-027 With the macro: a 16-bit counter clears on entry to ADDR and increments each ADDR or DATA cycle; when it reaches TIMEOUT, bus_err <= 1 (sticky until reset), state -> IDLE, w_valid stays 0 and the record is dropped.

Structure
REQ-028 The state enum (IDLE/ADDR/DATA), the plr_w valM field, and the dbus_req_t/dbus_resp_t types SHALL live in the shared defs package.
REQ-029 The watchdog SHALL be a sub-module named mem_resp_watchdog, instantiated only under MEM_RESP_WATCHDOG_EN.

Verification
REQ-030 ADDIU record (valE=32'h10, dreq_in.valid=0) -> next cycle w_valid=1, r_w.valE=32'h10, valM=0, stall never high.
REQ-031 LW addr 32'h80000100; addr_ok at cycle 2, data_ok at cycle 4 with data 32'hDEADBEEF -> stall high cycles 0-4, dreq.valid high cycles 1-2 only, w_valid pulse at cycle 5 with valM=32'hDEADBEEF.
REQ-032 SW with addr_ok and data_ok in the same cycle -> direct ADDR->IDLE, one w_valid pulse, valM=0, strobe=4'b1111 on the bus.
REQ-033 dreq_in changed while in ADDR -> dreq still shows the original address and data.
REQ-034 Reset asserted in DATA, then data_ok=1 -> no w_valid, state IDLE, dreq.valid=0.
REQ-035 Watchdog enabled, TIMEOUT=8, addr_ok never given -> bus_err=1 after 8 wait cycles, state IDLE, no w_valid.
